// File: rtl/edge_pkg.sv
`default_nettype none
// =============================================================================
// edge_pkg : shared edge-mode encodings and clog2 helper for edge_detect_multi
// Revision : 1.0
// =============================================================================
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_chan.sv
`default_nettype none
// =============================================================================
// edge_chan : one channel - synchroniser, stability filter, edge pulse,
//             sticky flag and saturating event counter
// Revision  : 1.0
// =============================================================================
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_din,
  input  logic [1:0]       i_mode,
  input  logic             i_clr,
  output logic             o_level,
  output logic             o_pulse,
  output logic             o_flag,
  output logic [CNT_W-1:0] o_count
);

  localparam int c_FC_RAW = clog2(FILT_CYCLES + 1);
  localparam int c_FC_W   = (c_FC_RAW < 1) ? 1 : c_FC_RAW;
  localparam logic [c_FC_W-1:0] c_FC_MAX  = c_FC_W'(FILT_CYCLES);
  localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_FC_W-1:0]      r_fc;
  logic                   r_level;
  logic                   r_pulse;
  logic                   r_flag;
  logic [CNT_W-1:0]       r_count;

  logic       w_s;
  logic       w_chg;
  logic       w_rise;
  logic       w_fall;
  logic       w_pulse_nxt;
  edge_mode_e w_mode;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_chg  = (w_s != r_level) && (r_fc == c_FC_MAX);
  assign w_rise = w_chg & w_s;
  assign w_fall = w_chg & ~w_s;
  assign w_mode = edge_mode_e'(i_mode);

  assign w_pulse_nxt = (w_rise && (w_mode == EDGE_RISE || w_mode == EDGE_BOTH)) ||
                       (w_fall && (w_mode == EDGE_FALL || w_mode == EDGE_BOTH));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync  <= '0;
      r_fc    <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_flag  <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};

      if (w_s == r_level) begin
        r_fc <= '0;
      end else if (w_chg) begin
        r_level <= w_s;
        r_fc    <= '0;
      end else begin
        r_fc <= r_fc + c_FC_W'(1);
      end

      r_pulse <= w_pulse_nxt;

      // A pulse arriving with a clear wins so no event is lost.
      if (r_pulse)    r_flag <= 1'b1;
      else if (i_clr) r_flag <= 1'b0;

      if (i_clr)                               r_count <= CNT_W'(r_pulse);
      else if (r_pulse && r_count != c_CNT_MAX) r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;
  assign o_flag  = r_flag;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/edge_detect_multi.sv
`default_nettype none
// =============================================================================
// edge_detect_multi : N-channel synchronising, glitch-filtered edge detector
// Revision          : 1.0
// =============================================================================
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N-1:0]       DIN,
  input  logic [2*N-1:0]     MODE,
  input  logic [N-1:0]       CLR,
  output logic [N-1:0]       LEVEL,
  output logic [N-1:0]       PULSE,
  output logic [N-1:0]       FLAG,
  output logic [N*CNT_W-1:0] COUNT,
  output logic               ANY
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .CLK    (CLK),
      .RST    (RST),
      .i_din  (DIN[i]),
      .i_mode (MODE[2*i +: 2]),
      .i_clr  (CLR[i]),
      .o_level(LEVEL[i]),
      .o_pulse(PULSE[i]),
      .o_flag (FLAG[i]),
      .o_count(COUNT[i*CNT_W +: CNT_W])
    );
  end

  assign ANY = |PULSE;

endmodule
`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
`default_nettype none
// =============================================================================
// tb_edge_detect_multi : scoreboard bench for edge_detect_multi
// Revision             : 1.0
// =============================================================================
module tb_edge_detect_multi;

  localparam int N   = 4;
  localparam int CW  = 8;
  localparam int CW2 = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    DIN;
  logic [2*N-1:0]  MODE;
  logic [N-1:0]    CLR;
  logic [N-1:0]    LEVEL, PULSE, FLAG;
  logic [N*CW-1:0] COUNT;
  logic            ANY;
  logic [N-1:0]    LEVEL2, PULSE2, FLAG2;
  logic [N*CW2-1:0] COUNT2;
  logic            ANY2;

  edge_detect_multi #(.N(N), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .MODE(MODE), .CLR(CLR),
    .LEVEL(LEVEL), .PULSE(PULSE), .FLAG(FLAG), .COUNT(COUNT), .ANY(ANY)
  );

  edge_detect_multi #(.N(N), .CNT_W(CW2)) dut_sat (
    .CLK(CLK), .RST(RST), .DIN(DIN), .MODE(MODE), .CLR(CLR),
    .LEVEL(LEVEL2), .PULSE(PULSE2), .FLAG(FLAG2), .COUNT(COUNT2), .ANY(ANY2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ch;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc    = 0;
  int  tests  = 0;
  int  failed = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK)
    for (int i = 0; i < N; i++)
      if (PULSE[i] === 1'b1) obs_q.push_back('{i, cyc});

  task automatic apply_reset();
    RST  = 1'b1;
    DIN  = '0;
    CLR  = '0;
    MODE = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (LEVEL !== 4'h0) begin failed++; $display("FAIL reset_level: got %h want 0", LEVEL); end
    tests++;
    if (PULSE !== 4'h0 || ANY !== 1'b0) begin failed++; $display("FAIL reset_pulse: got %h/%b want 0/0", PULSE, ANY); end
    tests++;
    if (FLAG !== 4'h0) begin failed++; $display("FAIL reset_flag: got %h want 0", FLAG); end
    tests++;
    if (COUNT !== '0) begin failed++; $display("FAIL reset_count: got %h want 0", COUNT); end
    MODE = 8'hFF;
    repeat (20) @(negedge CLK);
    tests++;
    if (obs_q.size() != 0) begin
      failed++;
      $display("FAIL idle_pulse: got %0d pulses want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_latency();
    int  c;
    ev_t e, o;
    apply_reset();
    MODE = 8'h01;
    @(negedge CLK);
    c = cyc;
    DIN[0] = 1'b1;
    exp_q.push_back('{0, c + 6});
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      tests++;
      if (LEVEL[0] !== 1'b0 || PULSE[0] !== 1'b0) begin
        failed++;
        $display("FAIL latency_early: cycle +%0d level/pulse %b/%b want 0/0", k, LEVEL[0], PULSE[0]);
      end
    end
    @(negedge CLK);
    tests++;
    if (PULSE[0] !== 1'b1 || LEVEL[0] !== 1'b1) begin
      failed++; $display("FAIL latency_pulse: level/pulse %b/%b want 1/1", LEVEL[0], PULSE[0]);
    end
    tests++;
    if (FLAG[0] !== 1'b0 || COUNT[7:0] !== 8'd0) begin
      failed++; $display("FAIL latency_flag_early: flag/count %b/%0d want 0/0", FLAG[0], COUNT[7:0]);
    end
    @(negedge CLK);
    tests++;
    if (PULSE[0] !== 1'b0) begin failed++; $display("FAIL latency_width: pulse %b want 0", PULSE[0]); end
    tests++;
    if (FLAG[0] !== 1'b1 || COUNT[7:0] !== 8'd1) begin
      failed++; $display("FAIL latency_flag: flag/count %b/%0d want 1/1", FLAG[0], COUNT[7:0]);
    end
    DIN[0] = 1'b0;
    repeat (10) @(negedge CLK);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        failed++; $display("FAIL latency_sb: no pulse, want ch%0d at cycle %0d", e.ch, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.ch !== e.ch || o.cyc !== e.cyc) begin
          failed++; $display("FAIL latency_sb: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      failed++; $display("FAIL latency_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_glitch();
    int  c, lvl_hi;
    ev_t e, o;
    apply_reset();
    MODE = 8'b00_00_11_00;
    @(negedge CLK);
    DIN[1] = 1'b1;
    lvl_hi = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (k == 2) DIN[1] = 1'b0;
      if (LEVEL[1] === 1'b1) lvl_hi++;
    end
    tests++;
    if (lvl_hi != 0 || COUNT[15:8] !== 8'd0) begin
      failed++; $display("FAIL glitch_3: level-high cycles/count %0d/%0d want 0/0", lvl_hi, COUNT[15:8]);
    end
    @(negedge CLK);
    c = cyc;
    DIN[1] = 1'b1;
    exp_q.push_back('{1, c + 6});
    exp_q.push_back('{1, c + 10});
    lvl_hi = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (k == 3) DIN[1] = 1'b0;
      if (LEVEL[1] === 1'b1) lvl_hi++;
    end
    tests++;
    if (lvl_hi != 4) begin failed++; $display("FAIL glitch_4_level: got %0d cycles want 4", lvl_hi); end
    tests++;
    if (COUNT[15:8] !== 8'd2) begin failed++; $display("FAIL glitch_4_count: got %0d want 2", COUNT[15:8]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        failed++; $display("FAIL glitch_sb: no pulse, want ch%0d at cycle %0d", e.ch, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.ch !== e.ch || o.cyc !== e.cyc) begin
          failed++; $display("FAIL glitch_sb: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      failed++; $display("FAIL glitch_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_modes();
    int  c, any_hi;
    ev_t e, o;
    int  want_rise  [4] = '{0, 1, 0, 1};
    int  want_fall  [4] = '{0, 0, 1, 1};
    int  want_count [4] = '{0, 1, 1, 2};
    apply_reset();
    MODE = 8'b11_10_01_00;
    any_hi = 0;
    for (int ch = 0; ch < N; ch++) begin
      @(negedge CLK);
      if (ANY === 1'b1) any_hi++;
      c = cyc;
      DIN[ch] = 1'b1;
      if (want_rise[ch] != 0) exp_q.push_back('{ch, c + 6});
      if (want_fall[ch] != 0) exp_q.push_back('{ch, c + 16});
      for (int k = 0; k < 20; k++) begin
        @(negedge CLK);
        if (k == 9) DIN[ch] = 1'b0;
        if (ANY === 1'b1) any_hi++;
      end
    end
    repeat (2) @(negedge CLK);
    for (int ch = 0; ch < N; ch++) begin
      tests++;
      if (COUNT[ch*CW +: CW] !== CW'(want_count[ch])) begin
        failed++; $display("FAIL modes_count: ch%0d got %0d want %0d", ch, COUNT[ch*CW +: CW], want_count[ch]);
      end
    end
    tests++;
    if (any_hi != 4) begin failed++; $display("FAIL modes_any: got %0d high cycles want 4", any_hi); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        failed++; $display("FAIL modes_sb: no pulse, want ch%0d at cycle %0d", e.ch, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.ch !== e.ch || o.cyc !== e.cyc) begin
          failed++; $display("FAIL modes_sb: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      failed++; $display("FAIL modes_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_saturation_clear();
    int  c;
    ev_t e, o;
    apply_reset();
    MODE = 8'h55;
    repeat (5) begin
      @(negedge CLK);
      c = cyc;
      DIN[0] = 1'b1;
      exp_q.push_back('{0, c + 6});
      for (int k = 0; k < 12; k++) begin
        @(negedge CLK);
        if (k == 5) DIN[0] = 1'b0;
      end
    end
    repeat (2) @(negedge CLK);
    tests++;
    if (COUNT2[1:0] !== 2'd3) begin failed++; $display("FAIL sat_count: got %0d want 3", COUNT2[1:0]); end
    tests++;
    if (COUNT[7:0] !== 8'd5 || FLAG[0] !== 1'b1) begin
      failed++; $display("FAIL sat_wide: count/flag %0d/%b want 5/1", COUNT[7:0], FLAG[0]);
    end
    @(negedge CLK);
    c = cyc;
    DIN[0] = 1'b1;
    exp_q.push_back('{0, c + 6});
    repeat (6) @(negedge CLK);
    tests++;
    if (PULSE[0] !== 1'b1) begin failed++; $display("FAIL clr_setup: pulse %b want 1", PULSE[0]); end
    CLR[0] = 1'b1;
    @(negedge CLK);
    CLR[0] = 1'b0;
    tests++;
    if (FLAG[0] !== 1'b1 || COUNT[7:0] !== 8'd1 || COUNT2[1:0] !== 2'd1) begin
      failed++;
      $display("FAIL clr_with_set: flag/count/count2 %b/%0d/%0d want 1/1/1", FLAG[0], COUNT[7:0], COUNT2[1:0]);
    end
    @(negedge CLK);
    CLR[0] = 1'b1;
    @(negedge CLK);
    CLR[0] = 1'b0;
    tests++;
    if (FLAG[0] !== 1'b0 || COUNT[7:0] !== 8'd0 || COUNT2[1:0] !== 2'd0) begin
      failed++;
      $display("FAIL clr_alone: flag/count/count2 %b/%0d/%0d want 0/0/0", FLAG[0], COUNT[7:0], COUNT2[1:0]);
    end
    DIN[0] = 1'b0;
    repeat (8) @(negedge CLK);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        failed++; $display("FAIL sat_sb: no pulse, want ch%0d at cycle %0d", e.ch, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.ch !== e.ch || o.cyc !== e.cyc) begin
          failed++; $display("FAIL sat_sb: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      failed++; $display("FAIL sat_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_filter();
    int  c;
    ev_t e, o;
    apply_reset();
    MODE = 8'h01;
    @(negedge CLK);
    c = cyc;
    DIN[0] = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    // First edge with RST low is c+5; one rising pulse five edges later.
    exp_q.push_back('{0, c + 10});
    repeat (14) @(negedge CLK);
    tests++;
    if (COUNT[7:0] !== 8'd1 || FLAG[0] !== 1'b1) begin
      failed++; $display("FAIL midrst_count: count/flag %0d/%b want 1/1", COUNT[7:0], FLAG[0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        failed++; $display("FAIL midrst_sb: no pulse, want ch%0d at cycle %0d", e.ch, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.ch !== e.ch || o.cyc !== e.cyc) begin
          failed++; $display("FAIL midrst_sb: got ch%0d@%0d want ch%0d@%0d", o.ch, o.cyc, e.ch, e.cyc);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      failed++; $display("FAIL midrst_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  initial begin
    RST  = 1'b1;
    DIN  = '0;
    MODE = '0;
    CLR  = '0;
    test_reset();
    test_latency();
    test_glitch();
    test_modes();
    test_saturation_clear();
    test_reset_mid_filter();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
